// File: rtl/mem_access_unit_if.sv
// Control-unit side bus of mem_access_unit: request handshake, interrupt lines and readback.
// parity_err exists only when MEM_PARITY_EN is defined.
interface mem_access_unit_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  INT;
    logic                  int_ack;
    logic                  busy;
    logic                  ready;
    logic [DATA_WIDTH-1:0] busC;
    logic                  vec_valid;
    logic                  int_pending;
`ifdef MEM_PARITY_EN
    logic                  parity_err;
`endif

    modport master (
        output req, we, addr, wdata, INT, int_ack,
`ifdef MEM_PARITY_EN
        input  parity_err,
`endif
        input  busy, ready, busC, vec_valid, int_pending
    );

    modport slave (
        input  req, we, addr, wdata, INT, int_ack,
`ifdef MEM_PARITY_EN
        output parity_err,
`endif
        output busy, ready, busC, vec_valid, int_pending
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-port RAM behind MAR/MDR with wait-stated req/ready access and interrupt-vector fetch.
// Optional per-word even parity when MEM_PARITY_EN is defined.
module mem_access_unit #(
    parameter int unsigned           DATA_WIDTH      = 8,
    parameter int unsigned           ADDR_WIDTH      = 3,
    parameter int unsigned           WAIT_STATES     = 2,
    parameter logic [ADDR_WIDTH-1:0] INT_VECTOR_ADDR = '0
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);
    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
`ifdef MEM_PARITY_EN
    localparam int unsigned WordWidth = DATA_WIDTH + 1;
`else
    localparam int unsigned WordWidth = DATA_WIDTH;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StDone,
        StVecAccess,
        StVecDone
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] busc_q;
    logic                  we_q;
    logic [3:0]            wait_q;
    logic                  ready_q;
    logic                  vec_valid_q;
    logic                  busy_q;
    logic                  int_pending_q;
    logic                  vec_owed_q;
    logic                  int_prev_q;

    logic [WordWidth-1:0]  mem [Depth];
    logic [WordWidth-1:0]  rword;
    logic [WordWidth-1:0]  wword;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  int_set;
    logic                  vec_due;

    assign rword = mem[mar_q];

`ifdef MEM_PARITY_EN
    logic parity_err_q;
    logic perr;

    assign wword = {^mdr_q, mdr_q};
    assign rdata = rword[DATA_WIDTH-1:0];
    // Stored parity makes the whole word even, so any odd reduction is corruption.
    assign perr  = ^rword;
    assign bus.parity_err = parity_err_q;
`else
    assign wword = mdr_q;
    assign rdata = rword;
`endif

    // Edges while an interrupt is already pending are dropped; a fresh edge is served
    // in the same IDLE cycle it is seen, ahead of any req.
    assign int_set = bus.INT & ~int_prev_q & ~int_pending_q;
    assign vec_due = vec_owed_q | int_set;

    always_ff @(posedge clk) begin
        if (!rst && state_q == StDone && we_q) begin
            mem[mar_q] <= wword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            mar_q         <= '0;
            mdr_q         <= '0;
            busc_q        <= '0;
            we_q          <= 1'b0;
            wait_q        <= '0;
            ready_q       <= 1'b0;
            vec_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            int_pending_q <= 1'b0;
            vec_owed_q    <= 1'b0;
            int_prev_q    <= 1'b0;
`ifdef MEM_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            int_prev_q  <= bus.INT;
            ready_q     <= 1'b0;
            vec_valid_q <= 1'b0;
`ifdef MEM_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            if (int_set) begin
                int_pending_q <= 1'b1;
            end else if (bus.int_ack) begin
                int_pending_q <= 1'b0;
            end

            if (state_q == StIdle && vec_due) begin
                vec_owed_q <= 1'b0;
            end else if (int_set) begin
                vec_owed_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (vec_due) begin
                        mar_q   <= INT_VECTOR_ADDR;
                        wait_q  <= WaitLoad;
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_STATES == 0) ? StVecDone : StVecAccess;
                    end else if (bus.req) begin
                        mar_q   <= bus.addr;
                        mdr_q   <= bus.wdata;
                        we_q    <= bus.we;
                        wait_q  <= WaitLoad;
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_STATES == 0) ? StDone : StAccess;
                    end
                end
                StAccess: begin
                    if (wait_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StVecAccess: begin
                    if (wait_q == 4'd0) begin
                        state_q <= StVecDone;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StDone: begin
                    if (!we_q) begin
                        mdr_q  <= rdata;
                        busc_q <= rdata;
`ifdef MEM_PARITY_EN
                        parity_err_q <= perr;
`endif
                    end
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StVecDone: begin
                    busc_q      <= rdata;
                    vec_valid_q <= 1'b1;
`ifdef MEM_PARITY_EN
                    parity_err_q <= perr;
`endif
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.ready       = ready_q;
    assign bus.busC        = busc_q;
    assign bus.vec_valid   = vec_valid_q;
    assign bus.int_pending = int_pending_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with 2 wait states, one with none.
// Parity checks are built only when MEM_PARITY_EN is defined.
module tb_mem_access_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_access_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus2 ();
    mem_access_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus0 ();

    mem_access_unit #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(2), .INT_VECTOR_ADDR(3'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    mem_access_unit #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(0), .INT_VECTOR_ADDR(3'd0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_busc;
    } vec_t;

    vec_t vecs [10];

`ifdef MEM_PARITY_EN
    logic last_pe;
    logic early_pe;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One CPU access on the 2-wait-state instance; returns busC and timing seen at ready.
    task automatic access2(input logic w, input logic [2:0] a, input logic [7:0] d,
                           output logic [7:0] busc, output int lat, output int busy_n);
        int k;
        @(negedge clk);
        bus2.req   = 1'b1;
        bus2.we    = w;
        bus2.addr  = a;
        bus2.wdata = d;
        @(negedge clk);
        bus2.req = 1'b0;
        k        = 1;
        busy_n   = 0;
`ifdef MEM_PARITY_EN
        early_pe = 1'b0;
`endif
        while (!bus2.ready && k < 40) begin
            if (bus2.busy) busy_n++;
`ifdef MEM_PARITY_EN
            early_pe |= bus2.parity_err;
`endif
            @(negedge clk);
            k++;
        end
        lat  = k - 1;
        busc = bus2.busC;
`ifdef MEM_PARITY_EN
        last_pe = bus2.parity_err;
`endif
        @(negedge clk);
        check("ready_single_pulse", {31'd0, bus2.ready}, 32'd0);
    endtask

    logic [7:0] busc;
    int         lat;
    int         busy_n;
    int         k;
    int         nvec;
    int         vec_at;
    logic [7:0] vbus;
    int         nrdy;
    int         first_rdy;
    int         second_rdy;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        {bus2.req, bus2.we, bus2.INT, bus2.int_ack} = '0;
        {bus0.req, bus0.we, bus0.INT, bus0.int_ack} = '0;
        bus2.addr = '0; bus2.wdata = '0;
        bus0.addr = '0; bus0.wdata = '0;

        vecs[0] = '{1'b1, 3'd3, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 3'd3, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 3'd5, 8'h5A, 8'hA5};
        vecs[3] = '{1'b1, 3'd0, 8'h40, 8'hA5};
        vecs[4] = '{1'b1, 3'd2, 8'h77, 8'hA5};
        vecs[5] = '{1'b0, 3'd5, 8'h00, 8'h5A};
        vecs[6] = '{1'b0, 3'd2, 8'h00, 8'h77};
        vecs[7] = '{1'b1, 3'd3, 8'hFF, 8'h77};
        vecs[8] = '{1'b0, 3'd3, 8'h00, 8'hFF};
        vecs[9] = '{1'b0, 3'd0, 8'h00, 8'h40};

        repeat (2) @(negedge clk);
        check("reset_busC", {24'd0, bus2.busC}, 32'h00);
        check("reset_ready", {31'd0, bus2.ready}, 32'd0);
        check("reset_busy", {31'd0, bus2.busy}, 32'd0);
        check("reset_int_pending", {31'd0, bus2.int_pending}, 32'd0);
        check("reset_vec_valid", {31'd0, bus2.vec_valid}, 32'd0);
        check("reset_busC_ws0", {24'd0, bus0.busC}, 32'h00);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            access2(vecs[i].we, vecs[i].addr, vecs[i].wdata, busc, lat, busy_n);
            check($sformatf("vec%0d_busC", i), {24'd0, busc}, {24'd0, vecs[i].exp_busc});
            check($sformatf("vec%0d_latency", i), lat, 32'd3);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, 32'd3);
        end

        // Reset while a write to 5 sits in ACCESS: RAM[5] must keep 0x5A.
        @(negedge clk);
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 3'd5; bus2.wdata = 8'h99;
        @(negedge clk);
        bus2.req = 1'b0;
        check("abort_busy_in_access", {31'd0, bus2.busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy", {31'd0, bus2.busy}, 32'd0);
        check("abort_busC", {24'd0, bus2.busC}, 32'h00);
        check("abort_ready", {31'd0, bus2.ready}, 32'd0);
        rst = 1'b0;
        access2(1'b0, 3'd5, 8'h00, busc, lat, busy_n);
        check("abort_read5", {24'd0, busc}, 32'h5A);

        // INT edge and req in the same IDLE cycle: vector fetch first, held req after.
        @(negedge clk);
        bus2.INT = 1'b1; bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = 3'd2;
        k = 0;
        while (!bus2.vec_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("prio_vec_latency", k, 32'd4);
        check("prio_vec_busC", {24'd0, bus2.busC}, 32'h40);
        check("prio_int_pending", {31'd0, bus2.int_pending}, 32'd1);
        check("prio_no_ready", {31'd0, bus2.ready}, 32'd0);
        @(negedge clk);
        bus2.req = 1'b0;
        check("prio_req_accepted", {31'd0, bus2.busy}, 32'd1);
        k = 1;
        while (!bus2.ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("prio_req_latency", k, 32'd4);
        check("prio_req_busC", {24'd0, bus2.busC}, 32'h77);
        bus2.int_ack = 1'b1;
        @(negedge clk);
        bus2.int_ack = 1'b0;
        bus2.INT     = 1'b0;
        check("prio_ack_clears", {31'd0, bus2.int_pending}, 32'd0);

        // INT rises during a read; second edge before ack must not refetch.
        @(negedge clk);
        bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = 3'd3;
        @(negedge clk);
        bus2.req = 1'b0;
        bus2.INT = 1'b1;
        k = 1;
        while (!bus2.ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("midint_ready_latency", k, 32'd4);
        check("midint_read_busC", {24'd0, bus2.busC}, 32'hFF);
        nvec   = 0;
        vec_at = -1;
        vbus   = 8'h00;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (bus2.vec_valid) begin
                nvec++;
                if (vec_at < 0) begin
                    vec_at = i;
                    vbus   = bus2.busC;
                end
            end
            if (i == 1) bus2.INT = 1'b0;
            if (i == 2) bus2.INT = 1'b1;
        end
        check("midint_vec_after_ready", vec_at, 32'd4);
        check("midint_vec_busC", {24'd0, vbus}, 32'h40);
        check("midint_single_vec", nvec, 32'd1);
        check("midint_pending_held", {31'd0, bus2.int_pending}, 32'd1);
        bus2.int_ack = 1'b1;
        @(negedge clk);
        bus2.int_ack = 1'b0;
        check("midint_ack_clears", {31'd0, bus2.int_pending}, 32'd0);

        // INT edge coincident with int_ack: set wins.
        bus2.INT = 1'b0;
        @(negedge clk);
        bus2.INT = 1'b1; bus2.int_ack = 1'b1;
        @(negedge clk);
        bus2.int_ack = 1'b0;
        check("setwins_pending", {31'd0, bus2.int_pending}, 32'd1);
        k = 1;
        while (!bus2.vec_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("setwins_vec_busC", {24'd0, bus2.busC}, 32'h40);
        bus2.int_ack = 1'b1;
        @(negedge clk);
        bus2.int_ack = 1'b0;
        bus2.INT     = 1'b0;
        check("setwins_ack_clears", {31'd0, bus2.int_pending}, 32'd0);

        // Zero wait states: write then read addr 7, then back-to-back reads.
        @(negedge clk);
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 3'd7; bus0.wdata = 8'h3C;
        @(negedge clk);
        bus0.req = 1'b0;
        check("ws0_wr_busy", {31'd0, bus0.busy}, 32'd1);
        check("ws0_wr_not_ready_yet", {31'd0, bus0.ready}, 32'd0);
        @(negedge clk);
        check("ws0_wr_ready", {31'd0, bus0.ready}, 32'd1);
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 3'd7;
        @(negedge clk);
        bus0.req = 1'b0;
        check("ws0_rd_not_ready_yet", {31'd0, bus0.ready}, 32'd0);
        @(negedge clk);
        check("ws0_rd_ready", {31'd0, bus0.ready}, 32'd1);
        check("ws0_rd_busC", {24'd0, bus0.busC}, 32'h3C);
        bus0.req   = 1'b1;
        nrdy       = 0;
        first_rdy  = -1;
        second_rdy = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus0.ready) begin
                nrdy++;
                if (first_rdy < 0) first_rdy = i;
                else if (second_rdy < 0) second_rdy = i;
            end
        end
        bus0.req = 1'b0;
        check("ws0_b2b_first", first_rdy, 32'd2);
        check("ws0_b2b_spacing", second_rdy - first_rdy, 32'd2);
        check("ws0_b2b_count", nrdy, 32'd4);

`ifdef MEM_PARITY_EN
        access2(1'b1, 3'd4, 8'h0F, busc, lat, busy_n);
        access2(1'b0, 3'd4, 8'h00, busc, lat, busy_n);
        check("par_clean_err", {31'd0, last_pe}, 32'd0);
        @(negedge clk);
        dut.mem[4] <= dut.mem[4] ^ 9'h001;
        @(negedge clk);
        access2(1'b0, 3'd4, 8'h00, busc, lat, busy_n);
        check("par_flip_busC", {24'd0, busc}, 32'h0E);
        check("par_flip_err", {31'd0, last_pe}, 32'd1);
        check("par_flip_err_early", {31'd0, early_pe}, 32'd0);
        check("par_flip_err_after", {31'd0, bus2.parity_err}, 32'd0);
        access2(1'b0, 3'd3, 8'h00, busc, lat, busy_n);
        check("par_other_busC", {24'd0, busc}, 32'hFF);
        check("par_other_err", {31'd0, last_pe}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
